// File: rtl/priority_bit_scanner.sv
// rtl/priority_bit_scanner.sv - accepts a request vector and emits the index of every set bit in priority order
module priority_bit_scanner #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_vector,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(WIDTH)-1:0] out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(WIDTH):0]   bit_count
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic [IDX_W:0]     bit_count_q, bit_count_d;
  logic               in_hs, out_hs;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Later loop iterations overwrite earlier ones, so the scan direction sets priority.
  always_comb begin
    out_index = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_q[i]) out_index = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) out_index = IDX_W'(i);
      end
    end
  end

  always_comb begin
    out_last  = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    out_valid = (state_q == SCAN);
    in_ready  = (state_q == IDLE) | (out_valid & out_last & out_ready);
    in_hs     = in_valid & in_ready;
    out_hs    = out_valid & out_ready;
    bit_count = bit_count_q;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    bit_count_d = bit_count_q;
    if (out_hs) begin
      pending_d = pending_q & ~(WIDTH'(1) << out_index);
      if (out_last) state_d = IDLE;
    end
    // A non-zero vector accepted alongside the final output reloads without a bubble.
    if (in_hs && (in_vector != '0)) begin
      pending_d   = in_vector;
      bit_count_d = popcount(in_vector);
      state_d     = SCAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      bit_count_q <= bit_count_d;
    end
  end

endmodule

// File: tb/tb_priority_bit_scanner.sv
// tb/tb_priority_bit_scanner.sv - self-checking bench for priority_bit_scanner in both scan directions
module tb_priority_bit_scanner;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_vector = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  logic         m_in_ready, m_out_valid, m_out_last;
  logic [2:0]   m_out_index;
  logic [3:0]   m_bit_count;
  logic         l_in_ready, l_out_valid, l_out_last;
  logic [2:0]   l_out_index;
  logic [3:0]   l_bit_count;

  int tests = 0;
  int fails = 0;

  int q_m[$];
  int q_l[$];
  int exp_count = 0;

  priority_bit_scanner #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_vector(in_vector), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_index(m_out_index), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_last(m_out_last), .bit_count(m_bit_count)
  );

  priority_bit_scanner #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_vector(in_vector), .in_valid(in_valid),
    .in_ready(l_in_ready), .out_index(l_out_index), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_last(l_out_last), .bit_count(l_bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_m.delete();
    q_l.delete();
    exp_count = 0;
  endtask

  task automatic model_step();
    bit busy, last, rdy;
    int cnt;
    busy = (q_m.size() != 0);
    last = (q_m.size() == 1);
    rdy  = !busy || (last && out_ready);
    if (busy && out_ready) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (in_valid && rdy && (in_vector != 0)) begin
      q_m.delete();
      q_l.delete();
      cnt = 0;
      for (int i = W - 1; i >= 0; i--) if (in_vector[i]) begin q_m.push_back(i); cnt++; end
      for (int i = 0; i < W; i++) if (in_vector[i]) q_l.push_back(i);
      exp_count = cnt;
    end
  endtask

  task automatic check_outputs();
    bit busy;
    int rdy;
    busy = (q_m.size() != 0);
    rdy  = (!busy || (q_m.size() == 1 && out_ready)) ? 1 : 0;
    chk("msb_out_valid", m_out_valid, busy);
    chk("lsb_out_valid", l_out_valid, busy);
    chk("msb_in_ready", m_in_ready, rdy);
    chk("lsb_in_ready", l_in_ready, rdy);
    chk("msb_bit_count", m_bit_count, exp_count);
    chk("lsb_bit_count", l_bit_count, exp_count);
    if (busy) begin
      chk("msb_out_index", m_out_index, q_m[0]);
      chk("lsb_out_index", l_out_index, q_l[0]);
      chk("msb_out_last", m_out_last, (q_m.size() == 1) ? 1 : 0);
      chk("lsb_out_last", l_out_last, (q_l.size() == 1) ? 1 : 0);
    end
    if (!rst_n) begin
      chk("rst_out_index", m_out_index, 0);
      chk("rst_out_last", m_out_last, 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      check_outputs();
      @(posedge clk);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  // Holds in_valid until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W-1:0] v);
    int n;
    n = 0;
    in_vector = v;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!m_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_vector = W'($urandom);
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_in_ready", m_in_ready, 1);
    chk("lit_reset_out_valid", m_out_valid, 0);
    chk("lit_reset_bit_count", m_bit_count, 0);

    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'd100);
    @(negedge clk);
    chk("lit_100_msb_first", m_out_index, 6);
    chk("lit_100_lsb_first", l_out_index, 2);
    chk("lit_100_count", m_bit_count, 3);
    chk("lit_100_in_ready", m_in_ready, 0);
    @(negedge clk);
    chk("lit_100_msb_second", m_out_index, 5);
    chk("lit_100_mid_last", m_out_last, 0);
    @(negedge clk);
    chk("lit_100_msb_third", m_out_index, 2);
    chk("lit_100_msb_last", m_out_last, 1);
    chk("lit_100_lsb_third", l_out_index, 6);
    chk("lit_100_lsb_last", l_out_last, 1);

    @(posedge clk); #1;
    send(8'd1);
    @(negedge clk);
    chk("lit_1_index", m_out_index, 0);
    chk("lit_1_last", m_out_last, 1);
    chk("lit_1_count", m_bit_count, 1);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'd23);
    repeat (5) begin
      @(negedge clk);
      chk("lit_bp_index", m_out_index, 4);
      chk("lit_bp_valid", m_out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("lit_23_first", m_out_index, 4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_23_second", m_out_index, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_23_third", m_out_index, 1);
    @(posedge clk); #1;
    in_vector = 8'd34;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("lit_23_final", m_out_index, 0);
    chk("lit_23_final_last", m_out_last, 1);
    chk("lit_b2b_in_ready", m_in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_b2b_valid", m_out_valid, 1);
    chk("lit_b2b_index", m_out_index, 5);
    chk("lit_b2b_count", m_bit_count, 2);

    n = 0;
    while (m_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("drain_timeout", 0, 1);

    @(posedge clk); #1;
    send(8'd0);
    @(negedge clk);
    chk("lit_zero_valid", m_out_valid, 0);
    chk("lit_zero_count", m_bit_count, 2);

    @(posedge clk); #1;
    send(8'd255);
    @(negedge clk);
    chk("lit_255_first", m_out_index, 7);
    @(negedge clk);
    chk("lit_255_second", m_out_index, 6);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("lit_rst_mid_valid", m_out_valid, 0);
    chk("lit_rst_mid_count", m_bit_count, 0);
    chk("lit_rst_mid_lsb_valid", l_out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_in_ready", m_in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("lit_post_rst_no_output", m_out_valid, 0);
    end

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       in_vector = '0;
        1:       in_vector = W'($urandom & $urandom);
        default: in_vector = W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
